// File: rtl/window_pe_pkg.sv
// Shared definitions for the window MAC processing element: FSM states and
// elaboration-time sizing helpers.
package window_pe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } pe_state_t;

    function automatic int calc_n(input int k0, input int k1, input int ic);
        return k0 * k1 * ic;
    endfunction

    // Smallest accumulator that cannot overflow on a full-scale window.
    function automatic int acc_min_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed DATA_WIDTH x DATA_WIDTH multiplier feeding a wrapping ACC_WIDTH
// accumulator with synchronous clear and enable.
module mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_px,
    input  logic signed [DATA_WIDTH-1:0] i_wt,
    output logic signed [ACC_WIDTH-1:0]  o_acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] r_acc;

    // Operands are widened before the multiply so the full product is kept.
    assign w_prod     = PW'(i_px) * PW'(i_wt);
    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign o_acc      = r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule

// File: rtl/window_mac_pe.sv
// Window dot-product PE: captures one window via pe_ready/pe_ack, MACs one
// element per cycle, presents the result on valid/ready. Option: WINDOW_PE_RELU_EN.
module window_mac_pe
    import window_pe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_CHANNEL = 1,
    parameter int KERNEL_0   = 3,
    parameter int KERNEL_1   = 3,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [DATA_WIDTH*KERNEL_0*KERNEL_1*IN_CHANNEL-1:0]     i_data,
    input  logic                                                   i_valid,
    output logic                                                   pe_ready,
    output logic                                                   pe_ack,
    input  logic [DATA_WIDTH*KERNEL_0*KERNEL_1*IN_CHANNEL-1:0]     w_data,
    input  logic                                                   w_load,
    output logic [ACC_WIDTH-1:0]                                   o_result,
    output logic                                                   o_valid,
    input  logic                                                   o_ready
);

    localparam int N     = calc_n(KERNEL_0, KERNEL_1, IN_CHANNEL);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int VEC_W = DATA_WIDTH * N;

    if (ACC_WIDTH < acc_min_width(DATA_WIDTH, N)) begin : g_acc_width_chk
        $error("window_mac_pe: ACC_WIDTH too small for DATA_WIDTH and window size");
    end

    pe_state_t                    r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [VEC_W-1:0]             r_win;
    logic [VEC_W-1:0]             r_wt;
    logic signed [DATA_WIDTH-1:0] w_px;
    logic signed [DATA_WIDTH-1:0] w_wt;
    logic signed [ACC_WIDTH-1:0]  w_acc;
    logic                         w_capture;
    logic                         w_mac_en;

    function automatic logic signed [ACC_WIDTH-1:0] post_proc(
        input logic signed [ACC_WIDTH-1:0] a
    );
`ifdef WINDOW_PE_RELU_EN
        return (a < 0) ? '0 : a;
`else
        return a;
`endif
    endfunction

    assign pe_ready  = (r_state == IDLE) && !w_load;
    assign w_capture = pe_ready && i_valid;
    assign w_mac_en  = (r_state == MAC);
    assign w_px      = r_win[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_wt      = r_wt[r_cnt*DATA_WIDTH +: DATA_WIDTH];

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_capture),
        .i_en  (w_mac_en),
        .i_px  (w_px),
        .i_wt  (w_wt),
        .o_acc (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_win    <= '0;
            r_wt     <= '0;
            pe_ack   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_wt <= w_data;
                    end else if (i_valid) begin
                        r_win   <= i_data;
                        pe_ack  <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    pe_ack  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the finished accumulator.
                    if (!o_valid) begin
                        o_valid  <= 1'b1;
                        o_result <= post_proc(w_acc);
                    end else if (o_ready) begin
                        o_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_mac_pe.sv
// Directed self-checking bench for window_mac_pe (3x3x1, 8-bit data, 24-bit acc).
module tb_window_mac_pe;

    localparam int DW = 8;
    localparam int N  = 9;
    localparam int AW = 24;
    localparam int VW = DW * N;

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] i_data;
    logic          i_valid;
    logic          pe_ready;
    logic          pe_ack;
    logic [VW-1:0] w_data;
    logic          w_load;
    logic [AW-1:0] o_result;
    logic          o_valid;
    logic          o_ready;

    int checks   = 0;
    int failures = 0;

    window_mac_pe dut (
        .clk      (clk),
        .rst      (rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .pe_ready (pe_ready),
        .pe_ack   (pe_ack),
        .w_data   (w_data),
        .w_load   (w_load),
        .o_result (o_result),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            load;
        logic [VW-1:0] w;
        logic [VW-1:0] px;
        int            exp;
    } vec_t;

    vec_t tv[6];

    function automatic logic [VW-1:0] pack9(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
        int a[9];
        logic [VW-1:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        r = '0;
        for (int e = 0; e < 9; e++) r[e*DW +: DW] = a[e][DW-1:0];
        return r;
    endfunction

    function automatic logic [AW-1:0] model_out(input int v);
`ifdef WINDOW_PE_RELU_EN
        if (v < 0) v = 0;
`endif
        return v[AW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic load_w(input logic [VW-1:0] w);
        @(negedge clk);
        w_data = w;
        w_load = 1'b1;
        @(negedge clk);
        w_load = 1'b0;
    endtask

    // Presents a window and returns just after the capturing edge.
    task automatic capture(input logic [VW-1:0] px, input string tag);
        @(negedge clk);
        i_data  = px;
        i_valid = 1'b1;
        chk({tag, "_pe_ready_idle"}, 32'(pe_ready), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk({tag, "_pe_ack_high"}, 32'(pe_ack), 32'd1);
        chk({tag, "_pe_ready_busy"}, 32'(pe_ready), 32'd0);
    endtask

    // Waits (bounded) for o_valid; reports edges elapsed since the capture edge.
    task automatic wait_valid(input string tag, input int lat_offset, output int lat);
        bit got;
        got = 1'b0;
        lat = lat_offset;
        while (lat < 60 && !got) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) chk({tag, "_pe_ack_drop"}, 32'(pe_ack), 32'd0);
            if (o_valid) got = 1'b1;
        end
        chk({tag, "_valid_seen"}, 32'(got), 32'd1);
    endtask

    task automatic send_window(input logic [VW-1:0] px, input logic [AW-1:0] exp,
                               input string tag);
        int lat;
        capture(px, tag);
        wait_valid(tag, 0, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd11);
        chk({tag, "_result"}, 32'(o_result), 32'(exp));
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] held;
        int lat;

        tv[0] = '{1'b1, pack9(1,1,1,1,1,1,1,1,1), pack9(1,2,3,4,5,6,7,8,9), 45};
        tv[1] = '{1'b0, '0, pack9(0,0,0,0,1,2,0,5,6), 14};
        tv[2] = '{1'b1, pack9(-1,-1,-1,-1,-1,-1,-1,-1,-1), pack9(1,2,3,4,5,6,7,8,9), -45};
        tv[3] = '{1'b1, pack9(-128,-128,-128,-128,-128,-128,-128,-128,-128),
                  pack9(-128,-128,-128,-128,-128,-128,-128,-128,-128), 147456};
        tv[4] = '{1'b1, pack9(127,127,127,127,127,127,127,127,127),
                  pack9(-128,-128,-128,-128,-128,-128,-128,-128,-128), -146304};
        tv[5] = '{1'b1, pack9(1,-2,3,-4,5,-6,7,-8,9), pack9(2,2,2,2,2,2,2,2,2), 10};

        rst     = 1'b1;
        i_data  = '0;
        i_valid = 1'b0;
        w_data  = '0;
        w_load  = 1'b0;
        o_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_pe_ack", 32'(pe_ack), 32'd0);
        chk("rst_o_result", 32'(o_result), 32'd0);
        chk("rst_pe_ready", 32'(pe_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            if (tv[i].load) load_w(tv[i].w);
            send_window(tv[i].px, model_out(tv[i].exp), $sformatf("vec%0d", i));
        end

        // Downstream stall: result held, new window not acked until handshake.
        load_w(pack9(1,1,1,1,1,1,1,1,1));
        o_ready = 1'b0;
        capture(pack9(1,2,3,4,5,6,7,8,9), "stall");
        wait_valid("stall", 0, lat);
        chk("stall_result", 32'(o_result), 32'd45);
        held    = o_result;
        i_data  = pack9(0,0,0,0,1,2,0,5,6);
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("stall_valid_hold", 32'(o_valid), 32'd1);
            chk("stall_result_hold", 32'(o_result), 32'(held));
            chk("stall_pe_ready", 32'(pe_ready), 32'd0);
            chk("stall_no_ack", 32'(pe_ack), 32'd0);
        end
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", 32'(o_valid), 32'd0);
        chk("stall_release_no_ack", 32'(pe_ack), 32'd0);
        @(posedge clk);
        #1;
        chk("stall_next_ack", 32'(pe_ack), 32'd1);
        i_valid = 1'b0;
        wait_valid("stall2", 0, lat);
        chk("stall2_latency", 32'(lat), 32'd11);
        chk("stall2_result", 32'(o_result), 32'd14);
        @(posedge clk);
        #1;

        // Weight load and window offered together: load wins, capture follows.
        @(negedge clk);
        w_data  = pack9(2,2,2,2,2,2,2,2,2);
        w_load  = 1'b1;
        i_data  = pack9(1,2,3,4,5,6,7,8,9);
        i_valid = 1'b1;
        #1;
        chk("wl_pe_ready_low", 32'(pe_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("wl_no_ack", 32'(pe_ack), 32'd0);
        w_load = 1'b0;
        #1;
        chk("wl_pe_ready_back", 32'(pe_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("wl_ack", 32'(pe_ack), 32'd1);
        i_valid = 1'b0;
        wait_valid("wl", 0, lat);
        chk("wl_latency", 32'(lat), 32'd11);
        chk("wl_result", 32'(o_result), 32'd90);
        @(posedge clk);
        #1;

        // Reset in the middle of MAC aborts and clears the weights.
        capture(pack9(1,2,3,4,5,6,7,8,9), "rstmid");
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstmid_o_valid", 32'(o_valid), 32'd0);
        chk("rstmid_pe_ack", 32'(pe_ack), 32'd0);
        chk("rstmid_o_result", 32'(o_result), 32'd0);
        chk("rstmid_pe_ready", 32'(pe_ready), 32'd1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            chk("rstmid_quiet_ack", 32'(pe_ack), 32'd0);
            chk("rstmid_quiet_valid", 32'(o_valid), 32'd0);
        end
        send_window(pack9(1,2,3,4,5,6,7,8,9), '0, "postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
